// File: rtl/bram_port_master.sv
// ---------------------------------------------------------------------------
// bram_port_master
//
// Arbitrates two clients onto a single BRAM port. Each accepted request is
// registered onto the port one cycle later; read data returns to the owning
// client two cycles after the grant, tracked by a 2-stage valid/owner
// pipeline. A client may hold ownership across consecutive requests with
// its lock input (atomic read-modify-write).
//
// Optional feature: define SHADOW_REG_EN to build a shadow register that
// mirrors the last word written to SHADOW_ADDR. Without the macro, shadow
// is tied to zero.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   cN_req/we/lock           client N request, write enable, lock
//   cN_addr/wdata            client N address and write data
//   cN_gnt                   combinational grant for client N
//   cN_rvalid/rdata          client N read-data strobe and data
//   mem_addr/data/we         registered BRAM port controls
//   mem_q                    BRAM read data (one cycle after address)
//   shadow                   mirror of last write to SHADOW_ADDR
// ---------------------------------------------------------------------------
module bram_port_master #(
    parameter int                    DATA_WIDTH  = 16,
    parameter int                    ADDR_WIDTH  = 16,
    parameter logic [ADDR_WIDTH-1:0] SHADOW_ADDR = 16'h00d5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  c0_req,
    input  logic                  c0_we,
    input  logic                  c0_lock,
    input  logic [ADDR_WIDTH-1:0] c0_addr,
    input  logic [DATA_WIDTH-1:0] c0_wdata,
    input  logic                  c1_req,
    input  logic                  c1_we,
    input  logic                  c1_lock,
    input  logic [ADDR_WIDTH-1:0] c1_addr,
    input  logic [DATA_WIDTH-1:0] c1_wdata,
    output logic                  c0_gnt,
    output logic                  c1_gnt,
    output logic                  c0_rvalid,
    output logic                  c1_rvalid,
    output logic [DATA_WIDTH-1:0] c0_rdata,
    output logic [DATA_WIDTH-1:0] c1_rdata,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_we,
    input  logic [DATA_WIDTH-1:0] mem_q,
    output logic [DATA_WIDTH-1:0] shadow
);

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t state_reg, state_next;

    // Index of the client granted most recently; reset to 1 so that
    // client 0 wins the first contended cycle.
    logic last_reg;

    logic [1:0] req;
    logic [1:0] lock;
    logic [1:0] gnt;

    // Read pipeline: stage 1 covers the cycle the address sits on the
    // port, stage 2 the cycle mem_q is valid.
    logic v1_reg, o1_reg;
    logic v2_reg, o2_reg;

    logic                  sel;
    logic                  acc;
    logic                  acc_we;
    logic [ADDR_WIDTH-1:0] acc_addr;
    logic [DATA_WIDTH-1:0] acc_data;

    logic [1:0]            rvalid;
    logic [DATA_WIDTH-1:0] rdata [2];

    assign req  = {c1_req, c0_req};
    assign lock = {c1_lock, c0_lock};

    // Grant and next-state logic
    always_comb begin
        gnt        = 2'b00;
        state_next = state_reg;
        if (!rst) begin
            unique case (state_reg)
                ARB: begin
                    if (req[0] && req[1]) begin
                        gnt = last_reg ? 2'b01 : 2'b10;
                    end else begin
                        gnt = req;
                    end
                    if (gnt[0] && lock[0]) begin
                        state_next = LOCK0;
                    end else if (gnt[1] && lock[1]) begin
                        state_next = LOCK1;
                    end
                end
                LOCK0: begin
                    gnt = {1'b0, req[0]};
                    // A dropped request also releases the lock.
                    if (!req[0] || !lock[0]) begin
                        state_next = ARB;
                    end
                end
                LOCK1: begin
                    gnt = {req[1], 1'b0};
                    if (!req[1] || !lock[1]) begin
                        state_next = ARB;
                    end
                end
                default: begin
                    state_next = ARB;
                end
            endcase
        end
    end

    assign c0_gnt = gnt[0];
    assign c1_gnt = gnt[1];

    assign sel      = gnt[1];
    assign acc      = |gnt;
    assign acc_we   = sel ? c1_we    : c0_we;
    assign acc_addr = sel ? c1_addr  : c0_addr;
    assign acc_data = sel ? c1_wdata : c0_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ARB;
            last_reg  <= 1'b1;
            mem_addr  <= '0;
            mem_data  <= '0;
            mem_we    <= 1'b0;
            v1_reg    <= 1'b0;
            o1_reg    <= 1'b0;
            v2_reg    <= 1'b0;
            o2_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (acc) begin
                last_reg <= sel;
                mem_addr <= acc_addr;
                mem_data <= acc_data;
                mem_we   <= acc_we;
            end else begin
                // Idle: address and data hold, only the strobe drops.
                mem_we <= 1'b0;
            end
            v1_reg <= acc && !acc_we;
            o1_reg <= sel;
            v2_reg <= v1_reg;
            o2_reg <= o1_reg;
        end
    end

    // Route returning read data to its owner; the other client sees zero.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_client
            assign rvalid[gi] = v2_reg && (o2_reg == gi[0]);
            assign rdata[gi]  = rvalid[gi] ? mem_q : '0;
        end
    endgenerate

    assign c0_rvalid = rvalid[0];
    assign c1_rvalid = rvalid[1];
    assign c0_rdata  = rdata[0];
    assign c1_rdata  = rdata[1];

`ifdef SHADOW_REG_EN
    logic [DATA_WIDTH-1:0] shadow_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_reg <= '0;
        end else if (mem_we && (mem_addr == SHADOW_ADDR)) begin
            shadow_reg <= mem_data;
        end
    end

    assign shadow = shadow_reg;
`else
    assign shadow = '0;
`endif

endmodule

// File: tb/tb_bram_port_master.sv
module tb_bram_port_master;

    localparam int DW = 16;
    localparam int AW = 16;

`ifdef SHADOW_REG_EN
    localparam logic [31:0] SHADOW_EXP = 32'h0003;
`else
    localparam logic [31:0] SHADOW_EXP = 32'h0000;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          c0_req, c0_we, c0_lock;
    logic [AW-1:0] c0_addr;
    logic [DW-1:0] c0_wdata;
    logic          c1_req, c1_we, c1_lock;
    logic [AW-1:0] c1_addr;
    logic [DW-1:0] c1_wdata;
    logic          c0_gnt, c1_gnt, c0_rvalid, c1_rvalid;
    logic [DW-1:0] c0_rdata, c1_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          mem_we;
    logic [DW-1:0] mem_q;
    logic [DW-1:0] shadow;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    bram_port_master dut (
        .clk       (clk),
        .rst       (rst),
        .c0_req    (c0_req),
        .c0_we     (c0_we),
        .c0_lock   (c0_lock),
        .c0_addr   (c0_addr),
        .c0_wdata  (c0_wdata),
        .c1_req    (c1_req),
        .c1_we     (c1_we),
        .c1_lock   (c1_lock),
        .c1_addr   (c1_addr),
        .c1_wdata  (c1_wdata),
        .c0_gnt    (c0_gnt),
        .c1_gnt    (c1_gnt),
        .c0_rvalid (c0_rvalid),
        .c1_rvalid (c1_rvalid),
        .c0_rdata  (c0_rdata),
        .c1_rdata  (c1_rdata),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_we    (mem_we),
        .mem_q     (mem_q),
        .shadow    (shadow)
    );

    // Write-first BRAM with registered read, preloaded during reset.
    logic [DW-1:0] mem [256];

    always @(posedge clk) begin
        if (rst) begin
            mem[8'h10] <= 16'haaaa;
            mem[8'h20] <= 16'hbbbb;
            mem[8'hc8] <= 16'h1234;
            mem_q      <= '0;
        end else begin
            if (mem_we) mem[mem_addr[7:0]] <= mem_data;
            mem_q <= mem_we ? mem_data : mem[mem_addr[7:0]];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic clear_in();
        c0_req = 0; c0_we = 0; c0_lock = 0; c0_addr = '0; c0_wdata = '0;
        c1_req = 0; c1_we = 0; c1_lock = 0; c1_addr = '0; c1_wdata = '0;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic req0(input logic we, input logic lk, input logic [AW-1:0] a, input logic [DW-1:0] d);
        c0_req = 1; c0_we = we; c0_lock = lk; c0_addr = a; c0_wdata = d;
    endtask

    task automatic req1(input logic we, input logic lk, input logic [AW-1:0] a, input logic [DW-1:0] d);
        c1_req = 1; c1_we = we; c1_lock = lk; c1_addr = a; c1_wdata = d;
    endtask

    initial begin
        rst = 1;
        clear_in();
        c0_req = 1;
        c1_req = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt0",   32'(c0_gnt), 0);
        chk("rst_gnt1",   32'(c1_gnt), 0);
        chk("rst_we",     32'(mem_we), 0);
        chk("rst_addr",   32'(mem_addr), 0);
        chk("rst_data",   32'(mem_data), 0);
        chk("rst_rv0",    32'(c0_rvalid), 0);
        chk("rst_rv1",    32'(c1_rvalid), 0);
        chk("rst_shadow", 32'(shadow), 0);
        nxt();
        rst = 0;
        clear_in();

        // Contended reads alternate c0,c1,c0,c1; rvalids follow two cycles later.
        for (int i = 0; i < 6; i++) begin
            if (i < 4) begin
                req0(0, 0, 16'h0010, 16'h0);
                req1(0, 0, 16'h0020, 16'h0);
            end else begin
                clear_in();
            end
            @(negedge clk);
            chk($sformatf("rr_gnt0_%0d", i), 32'(c0_gnt), 32'((i < 4) && (i % 2 == 0)));
            chk($sformatf("rr_gnt1_%0d", i), 32'(c1_gnt), 32'((i < 4) && (i % 2 == 1)));
            chk($sformatf("rr_rv0_%0d", i),  32'(c0_rvalid), 32'((i >= 2) && (i % 2 == 0)));
            chk($sformatf("rr_rv1_%0d", i),  32'(c1_rvalid), 32'((i >= 2) && (i % 2 == 1)));
            chk($sformatf("rr_rd0_%0d", i),  32'(c0_rdata), ((i >= 2) && (i % 2 == 0)) ? 32'haaaa : 32'h0);
            chk($sformatf("rr_rd1_%0d", i),  32'(c1_rdata), ((i >= 2) && (i % 2 == 1)) ? 32'hbbbb : 32'h0);
            nxt();
        end

        // Single read: grant in T, address in T+1, data in T+2.
        req0(0, 0, 16'h00c8, 16'h0);
        @(negedge clk);
        chk("rd_gnt0", 32'(c0_gnt), 1);
        chk("rd_gnt1", 32'(c1_gnt), 0);
        nxt();
        clear_in();
        @(negedge clk);
        chk("rd_addr", 32'(mem_addr), 32'h00c8);
        chk("rd_we",   32'(mem_we), 0);
        chk("rd_rv_t1", 32'(c0_rvalid), 0);
        nxt();
        @(negedge clk);
        chk("rd_rv_t2", 32'(c0_rvalid), 1);
        chk("rd_data",  32'(c0_rdata), 32'h1234);
        chk("rd_rv1",   32'(c1_rvalid), 0);
        chk("rd_rd1",   32'(c1_rdata), 0);
        nxt();
        @(negedge clk);
        chk("rd_rv_t3",  32'(c0_rvalid), 0);
        chk("idle_addr", 32'(mem_addr), 32'h00c8);
        nxt();

        // Write followed immediately by a read of the same address.
        req0(1, 0, 16'h0040, 16'h5555);
        @(negedge clk);
        chk("wr_gnt0", 32'(c0_gnt), 1);
        nxt();
        req0(0, 0, 16'h0040, 16'h0);
        @(negedge clk);
        chk("wr_gnt0_b", 32'(c0_gnt), 1);
        chk("wr_we",     32'(mem_we), 1);
        chk("wr_addr",   32'(mem_addr), 32'h0040);
        chk("wr_data",   32'(mem_data), 32'h5555);
        nxt();
        clear_in();
        @(negedge clk);
        chk("wr_no_rv", 32'(c0_rvalid), 0);
        chk("wr_we_b",  32'(mem_we), 0);
        nxt();
        @(negedge clk);
        chk("raw_rv",   32'(c0_rvalid), 1);
        chk("raw_data", 32'(c0_rdata), 32'h5555);
        nxt();

        // c1 locked read-read-write while c0 waits.
        req0(0, 0, 16'h0020, 16'h0);
        req1(0, 1, 16'h0010, 16'h0);
        @(negedge clk);
        chk("lk_a_gnt1", 32'(c1_gnt), 1);
        chk("lk_a_gnt0", 32'(c0_gnt), 0);
        nxt();
        req1(0, 1, 16'h0010, 16'h0);
        @(negedge clk);
        chk("lk_b_gnt1", 32'(c1_gnt), 1);
        chk("lk_b_gnt0", 32'(c0_gnt), 0);
        nxt();
        req1(1, 0, 16'h0010, 16'h7777);
        @(negedge clk);
        chk("lk_c_gnt1", 32'(c1_gnt), 1);
        chk("lk_c_gnt0", 32'(c0_gnt), 0);
        chk("lk_c_rv1",  32'(c1_rvalid), 1);
        chk("lk_c_rd1",  32'(c1_rdata), 32'haaaa);
        nxt();
        c1_req = 0; c1_we = 0;
        @(negedge clk);
        chk("lk_d_gnt0", 32'(c0_gnt), 1);
        chk("lk_d_gnt1", 32'(c1_gnt), 0);
        chk("lk_d_rv1",  32'(c1_rvalid), 1);
        chk("lk_d_rd1",  32'(c1_rdata), 32'haaaa);
        nxt();
        clear_in();
        @(negedge clk);
        chk("lk_e_rv1", 32'(c1_rvalid), 0);
        chk("lk_e_rv0", 32'(c0_rvalid), 0);
        nxt();
        @(negedge clk);
        chk("lk_f_rv0", 32'(c0_rvalid), 1);
        chk("lk_f_rd0", 32'(c0_rdata), 32'hbbbb);
        nxt();

        // Lock released by a one-cycle request drop.
        req0(0, 1, 16'h0010, 16'h0);
        @(negedge clk);
        chk("ld_gnt0", 32'(c0_gnt), 1);
        nxt();
        clear_in();
        req1(0, 0, 16'h0020, 16'h0);
        @(negedge clk);
        chk("ld_held_gnt1", 32'(c1_gnt), 0);
        nxt();
        @(negedge clk);
        chk("ld_rel_gnt1", 32'(c1_gnt), 1);
        chk("ld_rv0",      32'(c0_rvalid), 1);
        chk("ld_rd0",      32'(c0_rdata), 32'h7777);
        nxt();
        clear_in();
        @(negedge clk);
        nxt();
        @(negedge clk);
        chk("ld_rv1", 32'(c1_rvalid), 1);
        chk("ld_rd1", 32'(c1_rdata), 32'hbbbb);
        chk("ld_rd0", 32'(c0_rdata), 0);
        nxt();

        // Shadow register.
        req0(1, 0, 16'h00d5, 16'h0003);
        @(negedge clk);
        chk("sh_gnt0", 32'(c0_gnt), 1);
        nxt();
        clear_in();
        @(negedge clk);
        chk("sh_t1", 32'(shadow), 0);
        nxt();
        @(negedge clk);
        chk("sh_t2", 32'(shadow), SHADOW_EXP);
        nxt();
        req1(1, 0, 16'h0030, 16'h9999);
        @(negedge clk);
        chk("sh_gnt1", 32'(c1_gnt), 1);
        nxt();
        clear_in();
        nxt();
        @(negedge clk);
        chk("sh_hold", 32'(shadow), SHADOW_EXP);
        nxt();

        // Reset while a read is in flight.
        req0(0, 0, 16'h00c8, 16'h0);
        @(negedge clk);
        chk("rs_gnt0", 32'(c0_gnt), 1);
        nxt();
        rst = 1;
        req0(0, 0, 16'h0010, 16'h0);
        req1(0, 0, 16'h0020, 16'h0);
        @(negedge clk);
        chk("rs_gnt0_hi", 32'(c0_gnt), 0);
        chk("rs_gnt1_hi", 32'(c1_gnt), 0);
        chk("rs_we",      32'(mem_we), 0);
        chk("rs_addr",    32'(mem_addr), 0);
        chk("rs_rv0",     32'(c0_rvalid), 0);
        nxt();
        @(negedge clk);
        chk("rs_rv0_b", 32'(c0_rvalid), 0);
        nxt();
        rst = 0;
        clear_in();
        @(negedge clk);
        chk("rs_post_rv0", 32'(c0_rvalid), 0);
        chk("rs_post_rv1", 32'(c1_rvalid), 0);
        nxt();
        @(negedge clk);
        chk("rs_post_rv0_b", 32'(c0_rvalid), 0);
        nxt();
        req0(0, 0, 16'h0010, 16'h0);
        req1(0, 0, 16'h0020, 16'h0);
        @(negedge clk);
        chk("rs_first_gnt0", 32'(c0_gnt), 1);
        chk("rs_first_gnt1", 32'(c1_gnt), 0);
        nxt();
        clear_in();
        repeat (3) nxt();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/bram_port_master.md
BRAM_PORT_MASTER -- requirements
Module: bram_port_master

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, 16, data word width; ADDR_WIDTH, 16, address width; SHADOW_ADDR, 16'h00d5, address mirrored by the shadow register.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 rst  in  1  reset, asynchronous, active-high.
REQ-004 c0_req, c1_req  in  1  client n requests one memory access; held with its fields until granted.
REQ-005 c0_we, c1_we  in  1  1 = write, 0 = read.
REQ-006 c0_lock, c1_lock  in  1  keep ownership for the client's next request (atomic read-modify-write).
REQ-007 c0_addr, c1_addr  in  ADDR_WIDTH  access address.
REQ-008 c0_wdata, c1_wdata  in  DATA_WIDTH  write data.
REQ-009 c0_gnt, c1_gnt  out  1  combinational; request accepted this cycle.
REQ-010 c0_rvalid, c1_rvalid  out  1  one-cycle pulse; read data valid.
REQ-011 c0_rdata, c1_rdata  out  DATA_WIDTH  read data, meaningful only with rvalid.
REQ-012 mem_addr  out  ADDR_WIDTH  registered address to BRAM port.
REQ-013 mem_data  out  DATA_WIDTH  registered write data to BRAM port.
REQ-014 mem_we  out  1  registered write enable to BRAM port.
REQ-015 mem_q  in  DATA_WIDTH  BRAM port read data, valid one cycle after the BRAM samples the address.
REQ-016 shadow  out  DATA_WIDTH  mirror of last word written to SHADOW_ADDR.

Function
REQ-017 At most one gnt SHALL be high per cycle; gnt SHALL depend only on req, lock state and round-robin pointer.
REQ-018 State machine SHALL have states ARB, LOCK0, LOCK1.
REQ-019 In ARB with both req high, grant SHALL go to the client not granted most recently; with one req, that client; pointer SHALL update on each grant.
REQ-020 A grant with lock=1 SHALL move ARB to LOCKn (n = granted client); in LOCKn only client n SHALL be grantable.
REQ-021 LOCKn SHALL return to ARB when client n is granted with lock=0, or when cn_req is low for one cycle.
REQ-022 Accept in cycle T SHALL register mem_addr/mem_data/mem_we at the end of T, driving them during T+1.
REQ-023 Cycles with no grant SHALL drive mem_we=0 during the following cycle; mem_addr/mem_data SHALL hold.
REQ-024 For a read accepted in cycle T, cn_rvalid SHALL be high in cycle T+2 only, with cn_rdata = mem_q.
REQ-025 Writes SHALL produce no rvalid.
REQ-026 A 2-stage valid/owner pipeline SHALL track reads; back-to-back reads SHALL yield back-to-back rvalids in grant order; throughput one access per cycle.
REQ-027 Read to an address written in the immediately preceding accept SHALL return the new data (BRAM write-first port behaviour).
REQ-028 rdata of the non-owning client SHALL be 0.

Reset
REQ-029 rst high SHALL force: state ARB, pointer favouring client 0, mem_we=0, mem_addr=0, mem_data=0, all rvalid=0, shadow=0, pipeline cleared.
REQ-030 Reads in flight at rst SHALL be dropped; no rvalid SHALL follow reset release.
REQ-031 gnt SHALL be 0 while rst is high.

Configuration
REQ-032 Macro SHADOW_REG_EN defined: shadow SHALL load mem_data at the end of each cycle in which mem_we=1 and mem_addr == SHADOW_ADDR.
REQ-033 Macro SHADOW_REG_EN undefined: shadow SHALL be constant 0 with no register inferred; all other behaviour unchanged.

Verification
REQ-034 c0 read addr 0x00c8, mem holds 0x1234 -> c0_gnt in T, mem_addr=0x00c8 in T+1, c0_rvalid with 0x1234 in T+2.
REQ-035 c0 and c1 req together 4 cycles, reads -> grants alternate c0,c1,c0,c1; four rvalids in the same order, 2 cycles after each grant.
REQ-036 c1 lock read 0x0010 then write 0x0010 while c0 req held -> c0_gnt stays 0 until c1's unlocked write is granted; c0 granted next cycle.
REQ-037 SHADOW_REG_EN defined, c0 writes 0x0003 to 0x00d5 -> shadow=0x0003 from T+2; undefined -> shadow stays 0.
REQ-038 rst asserted in cycle T+1 after read grant in T -> no rvalid afterwards, mem_we=0, state ARB, next simultaneous request granted to c0.
